// File: rtl/layer_mem_responder.sv
// layer_mem_responder: responder for the convolution engine's layer memory.
// Holds the L0 (conv+ReLU) and L1 (max-pool) banks. After every reset it
// zero-fills both banks, then serves cwr/crd requests.
// Ports:
//   clk       - clock, all state on rising edge
//   reset     - asynchronous active-low reset
//   cwr       - write strobe; caddr_wr / cdata_wr give address and data
//   crd       - read strobe; caddr_rd gives address
//   csel      - bank select shared by read and write
//   cdata_rd  - registered read data (1-cycle latency, held until next accepted read)
//   mem_ready - high once the zero-fill is done
//   err       - sticky flags: [0] bad csel, [1] address out of range, [2] request while not ready
module layer_mem_responder #(
  parameter int unsigned DW       = 20,
  parameter int unsigned AW       = 12,
  parameter int unsigned L0_DEPTH = 4096,
  parameter int unsigned L1_DEPTH = 1024,
  parameter logic [2:0]  CSEL_L0  = 3'b001,
  parameter logic [2:0]  CSEL_L1  = 3'b011
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  input  logic [2:0]    csel,
  output logic [DW-1:0] cdata_rd,
  output logic          mem_ready,
  output logic [2:0]    err
);

  localparam int unsigned L0_AW = $clog2(L0_DEPTH);
  localparam int unsigned L1_AW = $clog2(L1_DEPTH);

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e            state_q, state_d;
  logic [L0_AW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     cdata_rd_q, cdata_rd_d;
  logic              mem_ready_q, mem_ready_d;
  logic [2:0]        err_q, err_d;

  logic [DW-1:0]     l0_mem [L0_DEPTH];
  logic [DW-1:0]     l1_mem [L1_DEPTH];

  logic              sel_l0_c, sel_l1_c, sel_ok_c;
  logic              wr_in_range_c, rd_in_range_c;
  logic              wr_ok_c, rd_ok_c;
  logic              l0_we_c, l1_we_c;
  logic [L0_AW-1:0]  l0_waddr_c;
  logic [L1_AW-1:0]  l1_waddr_c;
  logic [DW-1:0]     wdata_c;
  logic [DW-1:0]     rdata_c;

  // Bank decode and full-width range checks (no wrap on the address)
  assign sel_l0_c      = (csel == CSEL_L0);
  assign sel_l1_c      = (csel == CSEL_L1);
  assign sel_ok_c      = sel_l0_c | sel_l1_c;
  assign wr_in_range_c = sel_l0_c ? (32'(caddr_wr) < L0_DEPTH) : (32'(caddr_wr) < L1_DEPTH);
  assign rd_in_range_c = sel_l0_c ? (32'(caddr_rd) < L0_DEPTH) : (32'(caddr_rd) < L1_DEPTH);

  // Array read; the slice keeps the index legal, acceptance is decided below
  assign rdata_c = sel_l1_c ? l1_mem[caddr_rd[L1_AW-1:0]] : l0_mem[caddr_rd[L0_AW-1:0]];

  // Next-state, memory write port and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_ready_d = mem_ready_q;
    err_d       = err_q;
    cdata_rd_d  = cdata_rd_q;
    wr_ok_c     = 1'b0;
    rd_ok_c     = 1'b0;
    l0_we_c     = 1'b0;
    l1_we_c     = 1'b0;
    l0_waddr_c  = caddr_wr[L0_AW-1:0];
    l1_waddr_c  = caddr_wr[L1_AW-1:0];
    wdata_c     = cdata_wr;

    if ((cwr || crd) && !sel_ok_c) begin
      err_d[0] = 1'b1;
    end
    if (sel_ok_c && ((cwr && !wr_in_range_c) || (crd && !rd_in_range_c))) begin
      err_d[1] = 1'b1;
    end

    case (state_q)
      ST_CLEAR: begin
        if (cwr || crd) begin
          err_d[2] = 1'b1;
        end
        // Fill both banks in lockstep; L1 stops once its depth is covered
        l0_we_c    = 1'b1;
        l0_waddr_c = cnt_q;
        l1_we_c    = (32'(cnt_q) < L1_DEPTH);
        l1_waddr_c = cnt_q[L1_AW-1:0];
        wdata_c    = '0;
        cnt_d      = cnt_q + L0_AW'(1);
        if (32'(cnt_q) == L0_DEPTH - 1) begin
          state_d     = ST_READY;
          mem_ready_d = 1'b1;
        end
      end
      ST_READY: begin
        wr_ok_c = cwr && sel_ok_c && wr_in_range_c;
        rd_ok_c = crd && sel_ok_c && rd_in_range_c;
        l0_we_c = wr_ok_c && sel_l0_c;
        l1_we_c = wr_ok_c && sel_l1_c;
        // Write-first on a same-address collision
        if (rd_ok_c) begin
          cdata_rd_d = (wr_ok_c && (caddr_wr == caddr_rd)) ? cdata_wr : rdata_c;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      cdata_rd_q  <= '0;
      mem_ready_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cdata_rd_q  <= cdata_rd_d;
      mem_ready_q <= mem_ready_d;
      err_q       <= err_d;
    end
  end

  // Bank storage, cleared by the fill sequence rather than by reset
  always_ff @(posedge clk) begin
    if (l0_we_c) begin
      l0_mem[l0_waddr_c] <= wdata_c;
    end
    if (l1_we_c) begin
      l1_mem[l1_waddr_c] <= wdata_c;
    end
  end

  assign cdata_rd  = cdata_rd_q;
  assign mem_ready = mem_ready_q;
  assign err       = err_q;

endmodule

// File: tb/tb_layer_mem_responder.sv
module tb_layer_mem_responder;

  logic        clk;
  logic        reset;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [2:0]  csel;
  logic [19:0] cdata_rd;
  logic        mem_ready;
  logic [2:0]  err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [19:0] mb0 [4096];
  logic [19:0] mb1 [1024];
  logic [19:0] m_rd;
  logic [2:0]  m_err;
  bit          m_ready;
  int          m_cycles;

  layer_mem_responder dut (
    .clk      (clk),
    .reset    (reset),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .csel     (csel),
    .cdata_rd (cdata_rd),
    .mem_ready(mem_ready),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // After reset + fill both banks hold zero
  function automatic void model_reset();
    for (int i = 0; i < 4096; i++) mb0[i] = '0;
    for (int i = 0; i < 1024; i++) mb1[i] = '0;
    m_rd     = '0;
    m_err    = '0;
    m_ready  = 1'b0;
    m_cycles = 0;
  endfunction

  // One rising edge of the responder, written from the request rules
  function automatic void model_edge(input logic w, input logic [11:0] wa, input logic [19:0] wd,
                                     input logic r, input logic [11:0] ra, input logic [2:0] cs);
    bit vsel;
    int unsigned depth;
    int unsigned wai;
    int unsigned rai;
    bit wok;
    bit rok;
    vsel  = (cs == 3'b001) || (cs == 3'b011);
    depth = (cs == 3'b001) ? 4096 : 1024;
    wai   = wa;
    rai   = ra;
    if ((w || r) && !vsel) m_err[0] = 1'b1;
    if (vsel && ((w && wai >= depth) || (r && rai >= depth))) m_err[1] = 1'b1;
    if ((w || r) && !m_ready) m_err[2] = 1'b1;
    wok = m_ready && w && vsel && (wai < depth);
    rok = m_ready && r && vsel && (rai < depth);
    if (wok) begin
      if (cs == 3'b001) mb0[wai] = wd;
      else              mb1[wai] = wd;
    end
    if (rok) m_rd = (cs == 3'b001) ? mb0[rai] : mb1[rai];
    if (!m_ready) begin
      m_cycles++;
      if (m_cycles == 4096) m_ready = 1'b1;
    end
  endfunction

  task automatic step(input logic w, input logic [11:0] wa, input logic [19:0] wd,
                      input logic r, input logic [11:0] ra, input logic [2:0] cs);
    cwr      = w;
    caddr_wr = wa;
    cdata_wr = wd;
    crd      = r;
    caddr_rd = ra;
    csel     = cs;
    @(posedge clk);
    model_edge(w, wa, wd, r, ra, cs);
    #1;
    cwr = 1'b0;
    crd = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!mem_ready && n < 5000) begin
      step(1'b0, 12'h0, 20'h0, 1'b0, 12'h0, 3'b001);
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cwr = 1'b0; crd = 1'b0; caddr_wr = '0; caddr_rd = '0; cdata_wr = '0; csel = 3'b001;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (cdata_rd !== 20'h0) begin n_fail++; $display("FAIL reset_cdata_rd got=%h exp=0", cdata_rd); end
    n_tests++;
    if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ready got=%b exp=0", mem_ready); end
    n_tests++;
    if (err !== 3'b000) begin n_fail++; $display("FAIL reset_err got=%b exp=000", err); end
  endtask

  task automatic test_fill();
    int n;
    release_reset();
    wait_ready(n);
    n_tests++;
    if (n != 4096) begin n_fail++; $display("FAIL fill_cycles got=%0d exp=4096", n); end
    n_tests++;
    if (mem_ready !== m_ready) begin n_fail++; $display("FAIL fill_ready got=%b exp=%b", mem_ready, m_ready); end
    step(1'b0, 12'h0, 20'h0, 1'b1, 12'h000, 3'b001);
    n_tests++;
    if (cdata_rd !== 20'h0) begin n_fail++; $display("FAIL fill_l0_0 got=%h exp=0", cdata_rd); end
    step(1'b0, 12'h0, 20'h0, 1'b1, 12'hFFF, 3'b001);
    n_tests++;
    if (cdata_rd !== 20'h0) begin n_fail++; $display("FAIL fill_l0_4095 got=%h exp=0", cdata_rd); end
    step(1'b0, 12'h0, 20'h0, 1'b1, 12'h3FF, 3'b011);
    n_tests++;
    if (cdata_rd !== 20'h0) begin n_fail++; $display("FAIL fill_l1_1023 got=%h exp=0", cdata_rd); end
  endtask

  task automatic test_write_read();
    step(1'b1, 12'h041, 20'h0A89E, 1'b0, 12'h0, 3'b001);
    step(1'b0, 12'h0, 20'h0, 1'b1, 12'h041, 3'b001);
    n_tests++;
    if (cdata_rd !== 20'h0A89E) begin n_fail++; $display("FAIL wr_rd_data got=%h exp=0a89e", cdata_rd); end
    n_tests++;
    if (err !== 3'b000) begin n_fail++; $display("FAIL wr_rd_err got=%b exp=000", err); end
  endtask

  task automatic test_same_cycle();
    step(1'b1, 12'h005, 20'hFAC19, 1'b1, 12'h005, 3'b011);
    n_tests++;
    if (cdata_rd !== 20'hFAC19) begin n_fail++; $display("FAIL same_cycle_data got=%h exp=fac19", cdata_rd); end
    n_tests++;
    if (err !== 3'b000) begin n_fail++; $display("FAIL same_cycle_err got=%b exp=000", err); end
  endtask

  task automatic test_errors();
    step(1'b1, 12'h400, 20'h12345, 1'b0, 12'h0, 3'b011);
    n_tests++;
    if (err !== 3'b010) begin n_fail++; $display("FAIL range_err got=%b exp=010", err); end
    // Address 0x400 must not alias onto L1[0]
    step(1'b0, 12'h0, 20'h0, 1'b1, 12'h000, 3'b011);
    n_tests++;
    if (cdata_rd !== 20'h0) begin n_fail++; $display("FAIL range_no_alias got=%h exp=0", cdata_rd); end
    step(1'b0, 12'h0, 20'h0, 1'b1, 12'h005, 3'b011);
    step(1'b0, 12'h0, 20'h0, 1'b1, 12'h005, 3'b111);
    n_tests++;
    if (cdata_rd !== 20'hFAC19) begin n_fail++; $display("FAIL badsel_hold got=%h exp=fac19", cdata_rd); end
    n_tests++;
    if (err !== 3'b011) begin n_fail++; $display("FAIL badsel_err got=%b exp=011", err); end
  endtask

  task automatic test_random();
    logic        w, r;
    logic [11:0] wa, ra;
    logic [19:0] wd;
    logic [2:0]  cs;
    for (int i = 0; i < 600; i++) begin
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      wd = 20'($urandom());
      case ($urandom_range(0, 9))
        0:       cs = 3'($urandom());
        1, 2, 3: cs = 3'b011;
        default: cs = 3'b001;
      endcase
      case ($urandom_range(0, 7))
        0:       wa = 12'($urandom_range(1020, 1030));
        1:       wa = 12'($urandom_range(4090, 4095));
        default: wa = 12'($urandom_range(0, 15));
      endcase
      ra = ($urandom_range(0, 2) == 0) ? wa : 12'($urandom_range(0, 15));
      step(w, wa, wd, r, ra, cs);
      n_tests++;
      if (cdata_rd !== m_rd) begin n_fail++; $display("FAIL rand_data it=%0d got=%h exp=%h", i, cdata_rd, m_rd); end
      n_tests++;
      if (err !== m_err) begin n_fail++; $display("FAIL rand_err it=%0d got=%b exp=%b", i, err, m_err); end
    end
  endtask

  task automatic test_reset_mid_op();
    step(1'b1, 12'h007, 20'h12345, 1'b0, 12'h0, 3'b001);
    step(1'b0, 12'h0, 20'h0, 1'b1, 12'h007, 3'b001);
    n_tests++;
    if (cdata_rd !== 20'h12345) begin n_fail++; $display("FAIL pre_reset_data got=%h exp=12345", cdata_rd); end
    reset = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (cdata_rd !== 20'h0) begin n_fail++; $display("FAIL midop_reset_data got=%h exp=0", cdata_rd); end
    n_tests++;
    if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL midop_reset_ready got=%b exp=0", mem_ready); end
    n_tests++;
    if (err !== 3'b000) begin n_fail++; $display("FAIL midop_reset_err got=%b exp=000", err); end
  endtask

  task automatic test_clear_write();
    int n;
    release_reset();
    repeat (9) step(1'b0, 12'h0, 20'h0, 1'b0, 12'h0, 3'b001);
    step(1'b1, 12'h003, 20'h5A5A5, 1'b0, 12'h0, 3'b001);
    n_tests++;
    if (err !== 3'b100) begin n_fail++; $display("FAIL clear_write_err got=%b exp=100", err); end
    wait_ready(n);
    n_tests++;
    if (n != 4086) begin n_fail++; $display("FAIL clear_write_fill got=%0d exp=4086", n); end
    step(1'b0, 12'h0, 20'h0, 1'b1, 12'h003, 3'b001);
    n_tests++;
    if (cdata_rd !== 20'h0) begin n_fail++; $display("FAIL clear_write_dropped got=%h exp=0", cdata_rd); end
  endtask

  task automatic test_reset_midfill();
    int n;
    reset = 1'b0;
    model_reset();
    release_reset();
    for (int i = 0; i < 2000; i++) begin
      step(i == 100, 12'h010, 20'h00001, 1'b0, 12'h0, 3'b001);
    end
    n_tests++;
    if (err !== 3'b100 || mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL midfill_pre got err=%b rdy=%b exp err=100 rdy=0", err, mem_ready);
    end
    reset = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (mem_ready !== 1'b0 || err !== 3'b000 || cdata_rd !== 20'h0) begin
      n_fail++; $display("FAIL midfill_reset got rdy=%b err=%b data=%h exp 0/000/0", mem_ready, err, cdata_rd);
    end
    release_reset();
    wait_ready(n);
    n_tests++;
    if (n != 4096) begin n_fail++; $display("FAIL midfill_refill got=%0d exp=4096", n); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_same_cycle();
    test_errors();
    test_random();
    test_reset_mid_op();
    test_clear_write();
    test_reset_midfill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
